// File: rtl/alarm_disp_pkg.sv
// Shared types, constants and glyph table for the alarm panel 7-segment scan logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_disp_pkg;

    typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  en;
        logic [3:0]  blink;
    } snap_t;

    // Glyphs are {a,b,c,d,e,f,g}, active-low; b and d are lowercase forms.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low 7-segment glyph decoder.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module hex_to_seg
    import alarm_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller: per-frame input snapshot, ghost blanking, blink masking.
// Latency: seg/an registered, 1 cycle after the internal scan state; frame_tick 1 cycle after snapshot.
// Backpressure: none; free-running scan, inputs sampled once per frame only.
module seg_scan_ctrl
    import alarm_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  blink_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST      = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_PRE_DRIVE = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST     = BLINK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         idx;
    logic               blink_phase;
    snap_t              snap;
    scan_state_e        state, state_nx;

    logic       slot_wrap;
    logic       frame_start;
    logic       visible;
    logic [3:0] cur_nibble;
    logic [6:0] cur_glyph;
    logic [6:0] seg_nx;
    logic [3:0] an_nx;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_start = (idx == 2'd0) && (slot_cnt == '0);
    assign cur_nibble  = snap.digits[{idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nx;
        end
    end

    // State tracks slot_cnt: it enters DRIVE together with slot_cnt reaching BLANK_CYCLES.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_BLANK: if (slot_cnt == SLOT_PRE_DRIVE) state_nx = ST_DRIVE;
            ST_DRIVE: if (slot_wrap)                  state_nx = ST_BLANK;
        endcase
    end

    always_comb begin
        visible = snap.en[idx] && !(snap.blink[idx] && blink_phase);
        seg_nx  = SEG_BLANK;
        an_nx   = AN_OFF;
        if (state == ST_DRIVE && visible) begin
            an_nx  = ~(4'b0001 << idx);
            seg_nx = cur_glyph;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            idx         <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= '0;
            frame_tick  <= 1'b0;
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Snapshot only at frame start so a frame never mixes old and new digits.
            if (frame_start) begin
                snap <= '{digits: digits, en: digit_en, blink: blink_en};
            end
            frame_tick <= frame_start;

            seg <= seg_nx;
            an  <= an_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with small dividers: vector table, corner sequences and a frame-arithmetic reference model.
module tb_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BD = 64;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  blink_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .blink_en   (blink_en),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_ref(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[h];
    endfunction

    // Reference: n = clock edges since reset release; everything follows from n by plain arithmetic.
    function automatic logic [10:0] ref_out(input int n, input logic [15:0] d,
                                            input logic [3:0] en, input logic [3:0] bl);
        int slot = n % RD;
        int k    = (n / RD) % 4;
        bit ph   = ((n / BD) % 2) == 1;
        if (slot >= BC && en[k] && !(bl[k] && ph))
            return {~(4'b0001 << k), glyph_ref(d[4*k +: 4])};
        return {4'hF, 7'h7F};
    endfunction

    int          m_n;
    logic [15:0] m_d;
    logic [3:0]  m_en, m_bl;
    logic [11:0] exp_out;

    always @(posedge clk) begin
        if (reset) begin
            m_n     <= 0;
            m_d     <= '0;
            m_en    <= '0;
            m_bl    <= '0;
            exp_out <= {4'hF, 7'h7F, 1'b0};
        end else begin
            m_n <= m_n + 1;
            if (m_n % FRAME == 0) begin
                m_d  <= digits;
                m_en <= digit_en;
                m_bl <= blink_en;
            end
            exp_out <= {ref_out(m_n, m_d, m_en, m_bl), (m_n % FRAME) == 0};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic [3:0] last_an;
    bit         have_last = 1'b0;
    int         blank_run = 0;

    // Advance one cycle and compare against the model plus the anode invariants.
    task automatic tick();
        @(negedge clk);
        check("model", {an, seg, frame_tick}, exp_out);
        check("an_onecold", (an == 4'hF) || ($countones(~an) == 1), 1);
        if (an == 4'hF) begin
            blank_run++;
        end else begin
            if (have_last && an != last_an)
                check("ghost_gap", blank_run >= BC, 1);
            last_an   = an;
            have_last = 1'b1;
            blank_run = 0;
        end
    endtask

    task automatic apply_reset(input logic [15:0] d, input logic [3:0] en, input logic [3:0] bl);
        digits   = d;
        digit_en = en;
        blink_en = bl;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", {an, seg, frame_tick}, {4'hF, 7'h7F, 1'b0});
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  en;
        logic [3:0]  bl;
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[27];
    int   cnt_a, cnt_b, cnt_c, cnt_d;

    initial begin
        vecs[0]  = '{16'h1234, 4'hF, 4'h0,   4, 4'b1110, 7'b1001100};
        vecs[1]  = '{16'h1234, 4'hF, 4'h0,  12, 4'b1101, 7'b0000110};
        vecs[2]  = '{16'h1234, 4'hF, 4'h0,  20, 4'b1011, 7'b0010010};
        vecs[3]  = '{16'h1234, 4'hF, 4'h0,  28, 4'b0111, 7'b1001111};
        vecs[4]  = '{16'h1234, 4'hF, 4'h0,   1, 4'b1111, 7'b1111111};
        vecs[5]  = '{16'h1234, 4'hF, 4'h0,   2, 4'b1110, 7'b1001100};
        vecs[6]  = '{16'h1234, 4'hF, 4'h0,   7, 4'b1110, 7'b1001100};
        vecs[7]  = '{16'h1234, 4'hF, 4'h0,   9, 4'b1111, 7'b1111111};
        vecs[8]  = '{16'h1234, 4'hF, 4'h0,  10, 4'b1101, 7'b0000110};
        vecs[9]  = '{16'hABCD, 4'hF, 4'h0,   4, 4'b1110, 7'b1000010};
        vecs[10] = '{16'hABCD, 4'hF, 4'h0,  28, 4'b0111, 7'b0001000};
        vecs[11] = '{16'h5678, 4'h5, 4'h0,  12, 4'b1111, 7'b1111111};
        vecs[12] = '{16'h5678, 4'h5, 4'h0,  20, 4'b1011, 7'b0100000};
        vecs[13] = '{16'h5678, 4'h5, 4'h0,   4, 4'b1110, 7'b0000000};
        vecs[14] = '{16'h90EF, 4'hF, 4'h0,   4, 4'b1110, 7'b0111000};
        vecs[15] = '{16'h90EF, 4'hF, 4'h0,  12, 4'b1101, 7'b0110000};
        vecs[16] = '{16'h90EF, 4'hF, 4'h0,  20, 4'b1011, 7'b0000001};
        vecs[17] = '{16'h90EF, 4'hF, 4'h0,  28, 4'b0111, 7'b0000100};
        vecs[18] = '{16'hC7B8, 4'hF, 4'h0,  12, 4'b1101, 7'b1100000};
        vecs[19] = '{16'hC7B8, 4'hF, 4'h0,  20, 4'b1011, 7'b0001111};
        vecs[20] = '{16'hC7B8, 4'hF, 4'h0,  28, 4'b0111, 7'b0110001};
        vecs[21] = '{16'h0005, 4'h1, 4'h0,   4, 4'b1110, 7'b0100100};
        vecs[22] = '{16'h1234, 4'hF, 4'h1,  68, 4'b1111, 7'b1111111};
        vecs[23] = '{16'h1234, 4'hF, 4'h1,  76, 4'b1101, 7'b0000110};
        vecs[24] = '{16'h1234, 4'hF, 4'h1, 132, 4'b1110, 7'b1001100};
        vecs[25] = '{16'h1234, 4'hF, 4'h1,  36, 4'b1110, 7'b1001100};
        vecs[26] = '{16'h1234, 4'hF, 4'h0,  68, 4'b1110, 7'b1001100};

        reset    = 1'b1;
        digits   = '0;
        digit_en = '0;
        blink_en = '0;
        @(negedge clk);

        // Reset hold and first frame_tick one cycle after release.
        apply_reset(16'h1234, 4'hF, 4'h0);
        tick();
        check("first_frame_tick", frame_tick, 1'b1);
        tick();
        check("frame_tick_pulse", frame_tick, 1'b0);

        // Table: after reset release, probe the outputs produced by edge n.
        foreach (vecs[v]) begin
            apply_reset(vecs[v].d, vecs[v].en, vecs[v].bl);
            for (int n = 0; n <= vecs[v].n; n++) tick();
            check($sformatf("vec%0d_an", v), an, vecs[v].an);
            check($sformatf("vec%0d_seg", v), seg, vecs[v].seg);
        end

        // Mid-frame digit change has no effect until the next frame.
        apply_reset(16'h1234, 4'hF, 4'h0);
        for (int n = 0; n <= 36; n++) begin
            tick();
            if (n == 9)  digits = 16'hABCD;
            if (n == 20) check("tear_idx2", {an, seg}, {4'b1011, 7'b0010010});
            if (n == 28) check("tear_idx3", {an, seg}, {4'b0111, 7'b1001111});
            if (n == 32) check("tear_tick", frame_tick, 1'b1);
            if (n == 36) check("new_frame_d", {an, seg}, {4'b1110, 7'b1000010});
        end

        // Reset in the middle of a DRIVE slot.
        apply_reset(16'h1234, 4'hF, 4'h0);
        for (int n = 0; n <= 20; n++) tick();
        check("pre_reset_an", an, 4'b1011);
        reset = 1'b1;
        tick();
        check("abort_outs", {an, seg}, {4'hF, 7'h7F});
        reset = 1'b0;
        for (int n = 0; n <= 4; n++) begin
            tick();
            if (n == 0) check("restart_tick", frame_tick, 1'b1);
        end
        check("restart_idx0", {an, seg}, {4'b1110, 7'b1001100});

        // Blink spans on digit 0 only.
        apply_reset(16'h1234, 4'hF, 4'h1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int n = 0; n < 192; n++) begin
            tick();
            if (an == 4'b1110) begin
                if (n < 64)       cnt_a++;
                else if (n < 128) cnt_b++;
                else              cnt_c++;
            end
            if (n >= 64 && n < 128 && an == 4'b1101) cnt_d++;
        end
        check("blink_vis0", cnt_a, 12);
        check("blink_hidden", cnt_b, 0);
        check("blink_vis1", cnt_c, 12);
        check("blink_other", cnt_d, 12);

        // Disabled digits 1 and 3.
        apply_reset(16'h1234, 4'b0101, 4'h0);
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (!an[1] || !an[3]) cnt_a++;
            if (an == 4'b1011) cnt_b++;
        end
        check("dark_digits", cnt_a, 0);
        check("lit_digit2", cnt_b, 12);

        // Random inputs and occasional resets against the reference model.
        apply_reset(16'($urandom), 4'($urandom), 4'($urandom));
        for (int i = 0; i < 1500; i++) begin
            tick();
            reset = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                digits   = 16'($urandom);
                digit_en = 4'($urandom);
                blink_en = 4'($urandom);
            end
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
